// File: rtl/bus_pkg.sv
// Shared definitions for the multi-master bus interconnect: default widths,
// FSM state encoding and well-known slave indices.
package bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 64;

    localparam int RAM_IDX   = 0;
    localparam int FACTO_IDX = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Pointer width that stays at least one bit for the two-master case.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_interconnect_if.sv
// Bundle of the master-side and slave-side bus signals of the interconnect.
// Modports: master (a bus master), slave (a slave instance), fabric (the interconnect).
interface bus_interconnect_if #(
    parameter int NUM_MST = 2,
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = bus_pkg::ADDR_W_DEF,
    parameter int DATA_W  = bus_pkg::DATA_W_DEF
);
    logic [NUM_MST-1:0]        m_req;
    logic [NUM_MST-1:0]        m_wr;
    logic [NUM_MST*ADDR_W-1:0] m_addr;
    logic [NUM_MST*DATA_W-1:0] m_dout;
    logic [NUM_MST-1:0]        m_grant;
    logic [DATA_W-1:0]         m_din;

    logic [NUM_SLV-1:0]        s_sel;
    logic                      s_wr;
    logic [ADDR_W-1:0]         s_addr;
    logic [DATA_W-1:0]         s_din;
    logic [NUM_SLV*DATA_W-1:0] s_dout;

    logic                      dec_err;
    logic                      bus_err;

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, m_din, dec_err, bus_err
    );

    modport slave (
        input  s_sel, s_wr, s_addr, s_din,
        output s_dout
    );

    modport fabric (
        input  m_req, m_wr, m_addr, m_dout, s_dout,
        output m_grant, m_din, s_sel, s_wr, s_addr, s_din, dec_err, bus_err
    );

endinterface

// File: rtl/bus_interconnect_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last owner
// and wraps, returning a one-hot pick (all zero when nobody requests).
module rr_arbiter #(
    parameter int NUM_MST = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_MST-1:0] pick
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            idx = PTR_W'((int'(last) + k) % NUM_MST);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// NUM_MST-to-NUM_SLV shared bus with locked round-robin grants, upper-address
// decode and one-cycle read return. Optional grant watchdog: BUS_TIMEOUT_EN.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int NUM_MST   = 2,
    parameter int NUM_SLV   = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SLV_IDX_W = 4
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 256
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_interconnect_if.fabric bus
);

    localparam int PTR_W = ptr_width(NUM_MST);
    localparam int SEL_W = $clog2(NUM_SLV);

    state_t               state_reg;
    logic [NUM_MST-1:0]   grant_reg;
    logic [PTR_W-1:0]     owner_reg;
    logic [PTR_W-1:0]     last_reg;
    logic                 rd_valid_reg;
    logic [SEL_W-1:0]     rd_idx_reg;
    logic                 bus_err_reg;
`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0]     cnt_reg;
`endif

    logic [NUM_MST-1:0]   pick;
    logic [PTR_W-1:0]     pick_idx;
    logic                 granted;
    logic                 cur_wr;
    logic [ADDR_W-1:0]    cur_addr;
    logic [DATA_W-1:0]    cur_din;
    logic [SLV_IDX_W-1:0] slv_idx;
    logic                 unmapped;
    logic [DATA_W-1:0]    s_dout_arr [NUM_SLV];

    rr_arbiter #(
        .NUM_MST (NUM_MST),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req  (bus.m_req),
        .last (last_reg),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    // One-hot grant mux; with no grant every bus field collapses to zero.
    always_comb begin
        cur_wr   = 1'b0;
        cur_addr = '0;
        cur_din  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_reg[i]) begin
                cur_wr   = bus.m_wr[i];
                cur_addr = bus.m_addr[i*ADDR_W +: ADDR_W];
                cur_din  = bus.m_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    assign granted  = (state_reg == OWNED);
    assign slv_idx  = cur_addr[ADDR_W-1 -: SLV_IDX_W];
    assign unmapped = ({1'b0, slv_idx} >= (SLV_IDX_W+1)'(NUM_SLV));

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        assign bus.s_sel[gi]  = granted & ~unmapped & (slv_idx == SLV_IDX_W'(gi));
        assign s_dout_arr[gi] = bus.s_dout[gi*DATA_W +: DATA_W];
    end

    assign bus.m_grant = grant_reg;
    assign bus.s_addr  = cur_addr;
    assign bus.s_din   = cur_din;
    assign bus.s_wr    = granted & cur_wr & ~unmapped;
    assign bus.dec_err = granted & unmapped;
    assign bus.bus_err = bus_err_reg;
    assign bus.m_din   = rd_valid_reg ? s_dout_arr[rd_idx_reg] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            last_reg     <= PTR_W'(NUM_MST - 1);
            rd_valid_reg <= 1'b0;
            rd_idx_reg   <= '0;
            bus_err_reg  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_reg      <= '0;
`endif
        end else begin
            bus_err_reg  <= 1'b0;
            rd_valid_reg <= granted & ~cur_wr & ~unmapped;
            rd_idx_reg   <= slv_idx[SEL_W-1:0];
            case (state_reg)
                IDLE: begin
                    if (|bus.m_req) begin
                        grant_reg <= pick;
                        owner_reg <= pick_idx;
                        state_reg <= OWNED;
`ifdef BUS_TIMEOUT_EN
                        cnt_reg   <= '0;
`endif
                    end
                end
                OWNED: begin
                    // Releasing (or being revoked) always passes through IDLE.
                    if (!bus.m_req[owner_reg]) begin
                        grant_reg <= '0;
                        state_reg <= IDLE;
                        last_reg  <= owner_reg;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        grant_reg   <= '0;
                        state_reg   <= IDLE;
                        last_reg    <= owner_reg;
                        bus_err_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
